uart_bus_master: RTL and testbench

UART_BUS_MASTER -- requirements
Module: uart_bus_master

---
 rtl/uart_bus_master.sv | 160 ++++++++++++++++
 tb/tb_uart_bus_master.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_master.sv
// UART-driven bus master: decodes command/address/data byte frames from a UART
// receiver, runs one bus access, and returns a status byte plus any read data.
module uart_bus_master #(
  parameter logic [15:0] IDLE_TO = 16'd50000,
  parameter logic [7:0]  BUS_TO  = 8'd255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic [31:0] addr,
  output logic        w_rb,
  output logic [1:0]  acc,
  output logic [31:0] wdata,
  output logic        req,
  input  logic [31:0] rdata,
  input  logic        resp,
  input  logic        fault,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, STAT, RDAT} state_t;

  state_t      r_state, w_next;
  logic        r_wr, r_req;
  logic [1:0]  r_size, r_idx;
  logic [31:0] r_addr, r_wdata, r_rdat;
  logic [7:0]  r_bcnt, r_status;
  logic [15:0] r_gap;
  logic [1:0]  w_last;
  logic        w_gap_to, w_bus_done;

  // Index of the final byte of an N-byte field: 1B->0, 2B->1, 4B->3.
  assign w_last     = {r_size[1], |r_size};
  assign w_gap_to   = !rx_valid && (r_gap == IDLE_TO - 16'd1);
  assign w_bus_done = r_req && (fault || resp || (r_bcnt == BUS_TO));

  assign addr  = r_addr;
  assign w_rb  = r_wr;
  assign acc   = r_size;
  assign wdata = r_wdata;
  assign req   = r_req;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    busy     = (r_state != IDLE);
    case (r_state)
      IDLE: if (rx_valid) w_next = (rx_data[1:0] == 2'd3) ? STAT : ADDR;
      ADDR: begin
        if (rx_valid && r_idx == 2'd3) w_next = r_wr ? DATA : BUS;
        else if (w_gap_to)             w_next = IDLE;
      end
      DATA: begin
        if (rx_valid && r_idx == w_last) w_next = BUS;
        else if (w_gap_to)               w_next = IDLE;
      end
      BUS: if (w_bus_done) w_next = STAT;
      STAT: begin
        tx_valid = 1'b1;
        tx_data  = r_status;
        if (tx_ready) w_next = (!r_wr && r_status == 8'h00) ? RDAT : IDLE;
      end
      RDAT: begin
        tx_valid = 1'b1;
        tx_data  = r_rdat[{r_idx, 3'b000} +: 8];
        if (tx_ready && r_idx == w_last) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr     <= 1'b0;
      r_size   <= 2'd0;
      r_idx    <= 2'd0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_rdat   <= 32'd0;
      r_req    <= 1'b0;
      r_bcnt   <= 8'd0;
      r_status <= 8'd0;
      r_gap    <= 16'd0;
    end else begin
      case (r_state)
        IDLE: if (rx_valid) begin
          r_wr    <= rx_data[7];
          r_size  <= rx_data[1:0];
          r_idx   <= 2'd0;
          r_gap   <= 16'd0;
          r_wdata <= 32'd0;
          if (rx_data[1:0] == 2'd3) r_status <= 8'hFE;
        end
        ADDR: begin
          if (rx_valid) begin
            r_addr[{r_idx, 3'b000} +: 8] <= rx_data;
            r_gap <= 16'd0;
            r_idx <= r_idx + 2'd1;
            // Reads launch straight from the last address byte.
            if (r_idx == 2'd3 && !r_wr) begin
              r_req  <= 1'b1;
              r_bcnt <= 8'd1;
            end
          end else begin
            r_gap <= r_gap + 16'd1;
          end
        end
        DATA: begin
          if (rx_valid) begin
            r_wdata[{r_idx, 3'b000} +: 8] <= rx_data;
            r_gap <= 16'd0;
            r_idx <= r_idx + 2'd1;
            if (r_idx == w_last) begin
              r_req  <= 1'b1;
              r_bcnt <= 8'd1;
            end
          end else begin
            r_gap <= r_gap + 16'd1;
          end
        end
        BUS: if (r_req) begin
          // Fault outranks resp when both arrive together.
          if (fault) begin
            r_req    <= 1'b0;
            r_status <= 8'hFF;
          end else if (resp) begin
            r_req    <= 1'b0;
            r_status <= 8'h00;
            if (!r_wr) begin
              case (r_size)
                2'd0:    r_rdat <= {24'd0, rdata[7:0]};
                2'd1:    r_rdat <= {16'd0, rdata[15:0]};
                default: r_rdat <= rdata;
              endcase
            end
          end else if (r_bcnt == BUS_TO) begin
            r_req    <= 1'b0;
            r_status <= 8'hFD;
          end else begin
            r_bcnt <= r_bcnt + 8'd1;
          end
        end
        STAT: if (tx_ready) r_idx <= 2'd0;
        RDAT: if (tx_ready) r_idx <= r_idx + 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// Bench for uart_bus_master: directed frames plus randomized transactions,
// checked against a frame-level model of the expected bus access and reply bytes.
module tb_uart_bus_master;
  localparam logic [15:0] ITO = 16'd40;
  localparam logic [7:0]  BTO = 8'd10;

  logic        clk = 1'b0, rstn = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_data;
  logic [31:0] addr, wdata, rdata;
  logic        w_rb, req, resp, fault, busy;
  logic [1:0]  acc;

  always #5 clk = ~clk;

  uart_bus_master #(.IDLE_TO(ITO), .BUS_TO(BTO)) dut (
    .clk(clk), .rstn(rstn), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .addr(addr), .w_rb(w_rb), .acc(acc), .wdata(wdata), .req(req),
    .rdata(rdata), .resp(resp), .fault(fault), .busy(busy)
  );

  int total = 0, bad = 0;

  // Observations gathered by the bus/UART responder process.
  logic [7:0]  txq[$];
  int          npulse = 0, last_len = 0, sviol = 0, tviol = 0;
  logic [31:0] s_addr = 0, s_wdata = 0;
  logic        s_wrb = 0;
  logic [1:0]  s_acc = 0;

  // Responder configuration, written only by the stimulus process.
  int          cfg_rdly = 0, cfg_fdly = 0, cfg_stall = 0, cfg_id = 0;
  logic [31:0] cfg_rdata = 0;

  initial begin
    int rcyc = 0, seen = 0, stall_left = 0;
    logic hold = 1'b0;
    logic [7:0] hd = 8'h00;
    resp = 1'b0; fault = 1'b0; rdata = 32'd0; tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (hold && !(tx_valid && tx_data == hd)) tviol++;
      if (cfg_id != seen) begin seen = cfg_id; stall_left = cfg_stall; end
      if (tx_valid && stall_left > 0) begin tx_ready = 1'b0; stall_left--; end
      else tx_ready = ($urandom_range(3) != 0);
      if (tx_valid && tx_ready) txq.push_back(tx_data);
      hold = tx_valid && !tx_ready;
      hd   = tx_data;
      rdata = cfg_rdata;
      if (req) begin
        rcyc++;
        if (rcyc == 1) begin
          npulse++;
          s_addr = addr; s_wdata = wdata; s_wrb = w_rb; s_acc = acc;
        end else if (addr !== s_addr || wdata !== s_wdata || w_rb !== s_wrb || acc !== s_acc) begin
          sviol++;
        end
        last_len = rcyc;
        resp  = (rcyc == cfg_rdly);
        fault = (rcyc == cfg_fdly);
      end else begin
        rcyc  = 0;
        // Noise on resp/fault while req is low must be ignored.
        resp  = ($urandom_range(1) == 1);
        fault = ($urandom_range(1) == 1);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic set_cfg(input logic [31:0] rd, input int rdly, input int fdly, input int stall);
    cfg_rdata = rd; cfg_rdly = rdly; cfg_fdly = fdly; cfg_stall = stall;
    cfg_id++;
  endtask

  // rdly/fdly: req cycle (from 1) on which resp/fault is raised, 0 = never.
  task automatic run_txn(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] rd, input int rdly, input int fdly, input int stall);
    int n, base, p0, tv0, sv0, elen, tf, tr;
    logic [7:0]  st;
    logic [7:0]  exq[$];
    logic [31:0] ew;
    logic        ok;
    n  = 1 << cmd[1:0];
    ok = (cmd[1:0] != 2'd3);
    set_cfg(rd, rdly, fdly, stall);
    base = txq.size(); p0 = npulse; tv0 = tviol; sv0 = sviol;
    elen = 0;
    ew   = 32'd0;
    if (!ok) begin
      exq.push_back(8'hFE);
    end else begin
      tf = (fdly != 0) ? fdly : 1000;
      tr = (rdly != 0) ? rdly : 1000;
      if (tf <= tr && tf <= int'(BTO)) begin st = 8'hFF; elen = tf; end
      else if (tr <= int'(BTO))        begin st = 8'h00; elen = tr; end
      else                             begin st = 8'hFD; elen = int'(BTO); end
      exq.push_back(st);
      if (!cmd[7] && st == 8'h00)
        for (int i = 0; i < n; i++) exq.push_back(rd[8*i +: 8]);
      for (int i = 0; i < n; i++) ew[8*i +: 8] = d[8*i +: 8];
    end
    send(cmd);
    if (ok) begin
      for (int i = 0; i < 4; i++) send(a[8*i +: 8]);
      if (cmd[7]) for (int i = 0; i < n; i++) send(d[8*i +: 8]);
    end
    check("req_latency", 32'(req), 32'(ok));
    // A stray byte while the access/reply is in progress must be dropped.
    send(8'($urandom));
    for (int k = 0; k < 400 && busy; k++) tick();
    check("done_bound", 32'(busy), 32'd0);
    tick(); tick();
    check("tx_count", txq.size() - base, exq.size());
    for (int i = 0; i < exq.size(); i++)
      if (base + i < txq.size()) check("tx_byte", 32'(txq[base+i]), 32'(exq[i]));
    check("req_pulses", npulse - p0, 32'(ok));
    if (ok) begin
      check("addr", s_addr, a);
      check("w_rb", 32'(s_wrb), 32'(cmd[7]));
      check("acc", 32'(s_acc), 32'(cmd[1:0]));
      if (cmd[7]) check("wdata", s_wdata, ew);
      check("req_len", last_len, elen);
    end
    check("bus_stable", sviol - sv0, 0);
    check("tx_stable", tviol - tv0, 0);
  endtask

  initial begin
    int p0, b0;
    tick(); tick();
    check("rst_req", 32'(req), 0);
    check("rst_txv", 32'(tx_valid), 0);
    check("rst_txd", 32'(tx_data), 0);
    check("rst_addr", addr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_wrb", 32'(w_rb), 0);
    check("rst_acc", 32'(acc), 0);
    check("rst_busy", 32'(busy), 0);
    rstn = 1'b1;
    tick();

    run_txn(8'h82, 32'h20000010, 32'h12345678, 32'h0, 1, 0, 0);
    run_txn(8'h81, 32'h20000010, 32'h12345678, 32'h0, 2, 0, 0);
    run_txn(8'h00, 32'h20000003, 32'h0, 32'hAABBCCDD, 3, 0, 0);
    run_txn(8'h02, 32'h10000000, 32'h0, 32'h11223344, 0, 1, 0);
    run_txn(8'h03, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    run_txn(8'h01, 32'h00C0FFEE, 32'h0, 32'h5566A7B8, 0, 0, 0);
    run_txn(8'h7D, 32'h0BADF00D, 32'h0, 32'h99887766, 2, 2, 0);
    run_txn(8'h03, 32'h0, 32'h0, 32'h0, 0, 0, 20);
    run_txn(8'h01, 32'h40000004, 32'h0, 32'hCAFE1234, 2, 0, 20);

    // Partial frame then silence: abandoned without a reply or access.
    p0 = npulse; b0 = txq.size();
    send(8'h81); send(8'h10); send(8'h00);
    repeat (int'(ITO) + 1) tick();
    check("gap_idle", 32'(busy), 0);
    check("gap_noreq", npulse - p0, 0);
    check("gap_notx", txq.size() - b0, 0);
    run_txn(8'h02, 32'h20000010, 32'h0, 32'hDEADBEEF, 4, 0, 0);

    // Reset while a read is waiting on the bus.
    set_cfg(32'h0, 0, 0, 0);
    b0 = txq.size();
    send(8'h02);
    for (int i = 0; i < 4; i++) send(8'(i + 1));
    tick(); tick(); tick();
    rstn = 1'b0;
    tick();
    check("mid_rst_req", 32'(req), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_txv", 32'(tx_valid), 0);
    rstn = 1'b1;
    repeat (20) tick();
    check("mid_rst_notx", txq.size() - b0, 0);
    run_txn(8'h01, 32'h00001234, 32'h0, 32'h0000ABCD, 1, 0, 0);

    for (int t = 0; t < 12; t++) begin
      int rd, fd;
      rd = int'($urandom_range(12, 1));
      fd = ($urandom_range(1) == 1) ? int'($urandom_range(12, 1)) : 0;
      run_txn(8'($urandom), $urandom, $urandom, $urandom, rd, fd, int'($urandom_range(3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
